// File: rtl/sr165_pkg.sv
// Shared types and constants for the 74x165 chain reader.
package sr165_pkg;

    localparam int MIN_CLKDIV = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sr165_if.sv
// Device-side pins and word handshake of the 74x165 chain reader.
interface sr165_if #(
    parameter int NBITS = 8
);
    logic             start;
    logic             q7;
    logic             shld;
    logic             serclk;
    logic             busy;
    logic [NBITS-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  start, q7, out_ready,
        output shld, serclk, busy, out_data, out_valid
    );

    modport master (
        output start, q7, out_ready,
        input  shld, serclk, busy, out_data, out_valid
    );
endinterface

// File: rtl/sr165_sync2.sv
// Two-flop synchronizer for the asynchronous serial data line.
module sr165_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/sr165_reader.sv
// Reads a daisy chain of 74x165 shift registers: parallel load, then shift the
// chain out MSB-first and present the assembled word with a valid/ready handshake.
module sr165_reader
    import sr165_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NCHIPS = 1,
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    sr165_if.slave bus
);
    localparam int NBITS = WIDTH * NCHIPS;
    localparam int CNT_W = $clog2(NBITS + 1);
    localparam int DIV_W = 8;

    if (CLKDIV < MIN_CLKDIV || CLKDIV > 255) begin : g_bad_clkdiv
        $error("sr165_reader: CLKDIV out of range 3..255");
    end

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [NBITS-1:0]   shift_q, shift_d;
    logic [NBITS-1:0]   data_q, data_d;
    logic               shld_q, serclk_q, busy_q, valid_q;
    logic               q7_s;
    logic               div_last;

    sr165_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.q7),
        .q     (q7_s)
    );

    assign div_last = (div_q == DIV_W'(CLKDIV - 1));

    always_comb begin
        state_d = state_q;
        div_d   = div_q + DIV_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (bus.start) begin
                    state_d = ST_LOAD;
                    bit_d   = '0;
                end
            end
            ST_LOAD: begin
                if (div_last) begin
                    state_d = ST_SETTLE;
                    div_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (div_last) begin
                    state_d = ST_LOW;
                    div_d   = '0;
                end
            end
            ST_LOW: begin
                if (div_last) begin
                    // Sample at the end of LOW so the synchronizer has settled.
                    shift_d = NBITS'({shift_q, q7_s});
                    bit_d   = bit_q + CNT_W'(1);
                    div_d   = '0;
                    if (bit_q == CNT_W'(NBITS - 1)) begin
                        state_d = ST_DONE;
                        data_d  = NBITS'({shift_q, q7_s});
                    end else begin
                        state_d = ST_HIGH;
                    end
                end
            end
            ST_HIGH: begin
                if (div_last) begin
                    state_d = ST_LOW;
                    div_d   = '0;
                end
            end
            ST_DONE: begin
                div_d = '0;
                if (bus.out_ready) begin
                    if (bus.start) begin
                        state_d = ST_LOAD;
                        bit_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
        end
    end

    // Pin outputs are registered from the next state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shld_q   <= 1'b1;
            serclk_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            shld_q   <= (state_d != ST_LOAD);
            serclk_q <= (state_d == ST_HIGH);
            busy_q   <= (state_d != ST_IDLE);
            valid_q  <= (state_d == ST_DONE);
        end
    end

    assign bus.shld      = shld_q;
    assign bus.serclk    = serclk_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
endmodule

// File: tb/tb_sr165_reader.sv
// Bench for sr165_reader: three configurations driven by 74x165 chain models,
// with a cycle-level reference model of the expected pin and handshake behaviour.
module tb_sr165_reader;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic        start_v [3];
    logic        ready_v [3];
    logic [15:0] par     [3];
    logic [15:0] chain   [3];
    logic        shld_w  [3];
    logic        serclk_w[3];
    logic        busy_w  [3];
    logic        valid_w [3];
    logic [15:0] data_w  [3];

    sr165_if #(.NBITS(8))  ifa ();
    sr165_if #(.NBITS(16)) ifb ();
    sr165_if #(.NBITS(8))  ifc ();

    sr165_reader #(.WIDTH(8), .NCHIPS(1), .CLKDIV(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    sr165_reader #(.WIDTH(8), .NCHIPS(2), .CLKDIV(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    sr165_reader #(.WIDTH(8), .NCHIPS(1), .CLKDIV(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    assign ifa.start = start_v[0];  assign ifa.out_ready = ready_v[0];  assign ifa.q7 = chain[0][7];
    assign ifb.start = start_v[1];  assign ifb.out_ready = ready_v[1];  assign ifb.q7 = chain[1][15];
    assign ifc.start = start_v[2];  assign ifc.out_ready = ready_v[2];  assign ifc.q7 = chain[2][7];

    assign shld_w[0] = ifa.shld;  assign serclk_w[0] = ifa.serclk;  assign busy_w[0] = ifa.busy;
    assign shld_w[1] = ifb.shld;  assign serclk_w[1] = ifb.serclk;  assign busy_w[1] = ifb.busy;
    assign shld_w[2] = ifc.shld;  assign serclk_w[2] = ifc.serclk;  assign busy_w[2] = ifc.busy;
    assign valid_w[0] = ifa.out_valid;  assign data_w[0] = {8'h00, ifa.out_data};
    assign valid_w[1] = ifb.out_valid;  assign data_w[1] = ifb.out_data;
    assign valid_w[2] = ifc.out_valid;  assign data_w[2] = {8'h00, ifc.out_data};

    function automatic int cd(input int d);
        return (d == 2) ? 3 : 4;
    endfunction
    function automatic int nb(input int d);
        return (d == 1) ? 16 : 8;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d]: actual=%0h expected=%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // 74x165 chains: level-sensitive load while shld low, shift toward q7 on serclk rise.
    logic sc_prev[3];
    int   rise_cnt[3];
    int   shld_cnt[3];
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!shld_w[d])
                chain[d] <= par[d];
            else if (serclk_w[d] && !sc_prev[d])
                chain[d] <= chain[d] << 1;
            if (serclk_w[d] && !sc_prev[d]) rise_cnt[d]++;
            if (!shld_w[d]) shld_cnt[d]++;
            sc_prev[d] <= serclk_w[d];
        end
    end

    // Reference: 0 = idle, 1 = busy (m_e cycles elapsed), 2 = word presented.
    int          m_st[3];
    int          m_e [3];
    logic [15:0] m_word[3];
    logic [15:0] m_data[3];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                m_st[d]   <= 0;
                m_e[d]    <= 0;
                m_data[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                case (m_st[d])
                    0: if (start_v[d]) begin
                        m_st[d] <= 1; m_e[d] <= 0; m_word[d] <= par[d];
                    end
                    1: if (m_e[d] == cd(d) * (2 * nb(d) + 1) - 1) begin
                        m_st[d] <= 2; m_data[d] <= m_word[d];
                    end else begin
                        m_e[d] <= m_e[d] + 1;
                    end
                    default: if (ready_v[d]) begin
                        if (start_v[d]) begin
                            m_st[d] <= 1; m_e[d] <= 0; m_word[d] <= par[d];
                        end else begin
                            m_st[d] <= 0;
                        end
                    end
                endcase
            end
        end
    end

    function automatic logic exp_shld(input int d);
        return !(m_st[d] == 1 && m_e[d] < cd(d));
    endfunction
    function automatic logic exp_serclk(input int d);
        int p;
        p = m_e[d] / cd(d);
        return (m_st[d] == 1) && (p >= 2) && (p % 2 == 1);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                chk("shld",      d, 32'(shld_w[d]),   32'(exp_shld(d)));
                chk("serclk",    d, 32'(serclk_w[d]), 32'(exp_serclk(d)));
                chk("busy",      d, 32'(busy_w[d]),   32'(m_st[d] != 0));
                chk("out_valid", d, 32'(valid_w[d]),  32'(m_st[d] == 2));
                chk("out_data",  d, 32'(data_w[d]),   32'(m_data[d]));
            end
        end
    end

    task automatic launch(input int d, input logic [15:0] word);
        par[d] = word;
        @(negedge clk);
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input bit noise, output int lat, output int rises,
                             output int lows, output logic [15:0] data);
        int cyc, r0, s0;
        cyc = 0;
        r0  = rise_cnt[d];
        s0  = shld_cnt[d];
        while (!valid_w[d] && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (noise) start_v[d] = serclk_w[d] && ($urandom_range(0, 3) == 0);
        end
        start_v[d] = 1'b0;
        if (!valid_w[d]) chk("valid_timeout", d, 32'(valid_w[d]), 32'd1);
        lat   = cyc;
        rises = rise_cnt[d] - r0;
        lows  = shld_cnt[d] - s0;
        data  = data_w[d];
    endtask

    task automatic accept(input int d, input bit with_start, input logic [15:0] word);
        @(negedge clk);
        ready_v[d] = 1'b1;
        if (with_start) begin
            par[d]     = word;
            start_v[d] = 1'b1;
        end
        @(negedge clk);
        ready_v[d] = 1'b0;
        start_v[d] = 1'b0;
        if (with_start) chk("shld_fall", d, 32'(shld_w[d]), 32'd0);
    endtask

    task automatic reset_outputs_check(input int d);
        chk("rst_shld",   d, 32'(shld_w[d]),   32'd1);
        chk("rst_serclk", d, 32'(serclk_w[d]), 32'd0);
        chk("rst_busy",   d, 32'(busy_w[d]),   32'd0);
        chk("rst_valid",  d, 32'(valid_w[d]),  32'd0);
        chk("rst_data",   d, 32'(data_w[d]),   32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, rises, lows, r0, cyc;
        logic [15:0] data, word, mask;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0; ready_v[d] = 1'b0; par[d] = '0; chain[d] = '0;
            sc_prev[d] = 1'b0; rise_cnt[d] = 0; shld_cnt[d] = 0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) reset_outputs_check(d);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Single device, 0xA5, then hold the word with out_ready low.
        launch(0, 16'h00A5);
        wait_done(0, 1'b0, lat, rises, lows, data);
        chk("a5_data", 0, 32'(data), 32'h00A5);
        chk("a5_latency", 0, 32'(lat), 32'd68);
        chk("a5_rises", 0, 32'(rises), 32'd7);
        chk("a5_shld_low", 0, 32'(lows), 32'd4);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_valid", 0, 32'(valid_w[0]), 32'd1);
            chk("hold_data", 0, 32'(data_w[0]), 32'h00A5);
        end
        accept(0, 1'b0, 16'h0);

        // Two devices: nearest 0x3C, upstream 0xC3.
        launch(1, 16'h3CC3);
        wait_done(1, 1'b0, lat, rises, lows, data);
        chk("chain2_data", 1, 32'(data), 32'h3CC3);
        chk("chain2_latency", 1, 32'(lat), 32'd132);
        chk("chain2_rises", 1, 32'(rises), 32'd15);
        accept(1, 1'b0, 16'h0);

        // Start pulses during HIGH are ignored; then back-to-back FF / 00.
        launch(0, 16'h005A);
        wait_done(0, 1'b1, lat, rises, lows, data);
        chk("ignore_start_data", 0, 32'(data), 32'h005A);
        chk("ignore_start_latency", 0, 32'(lat), 32'd68);
        accept(0, 1'b1, 16'h00FF);
        wait_done(0, 1'b0, lat, rises, lows, data);
        chk("b2b_ff_data", 0, 32'(data), 32'h00FF);
        chk("b2b_ff_latency", 0, 32'(lat), 32'd68);
        accept(0, 1'b1, 16'h0000);
        wait_done(0, 1'b0, lat, rises, lows, data);
        chk("b2b_00_data", 0, 32'(data), 32'h0000);
        accept(0, 1'b0, 16'h0);

        // Reset during HIGH of bit 4, then a clean transaction.
        launch(0, 16'h0096);
        r0  = rise_cnt[0];
        cyc = 0;
        while (!((rise_cnt[0] - r0 >= 4) && serclk_w[0]) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_high4", 0, 32'(serclk_w[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1 reset_outputs_check(0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(0, 16'h003C);
        wait_done(0, 1'b0, lat, rises, lows, data);
        chk("post_rst_data", 0, 32'(data), 32'h003C);
        chk("post_rst_latency", 0, 32'(lat), 32'd68);
        accept(0, 1'b0, 16'h0);

        // Minimum divider.
        launch(2, 16'h0081);
        wait_done(2, 1'b0, lat, rises, lows, data);
        chk("div3_data", 2, 32'(data), 32'h0081);
        chk("div3_latency", 2, 32'(lat), 32'd51);
        chk("div3_shld_low", 2, 32'(lows), 32'd3);
        accept(2, 1'b0, 16'h0);

        // Randomized transactions across all configurations.
        for (int i = 0; i < 15; i++) begin
            int d;
            d    = int'($urandom_range(0, 2));
            mask = (nb(d) == 16) ? 16'hFFFF : 16'h00FF;
            word = 16'($urandom) & mask;
            launch(d, word);
            wait_done(d, 1'b1, lat, rises, lows, data);
            chk("rand_data", d, 32'(data), 32'(word));
            chk("rand_latency", d, 32'(lat), 32'(cd(d) * (2 * nb(d) + 1)));
            chk("rand_rises", d, 32'(rises), 32'(nb(d) - 1));
            chk("rand_shld_low", d, 32'(lows), 32'(cd(d)));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            accept(d, 1'b0, 16'h0);
        end

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sr165_reader.md
SR165_READER -- requirements
Module: sr165_reader

Interface
REQ-001 Parameter WIDTH, default 8, bits per 74x165 device.
REQ-002 Parameter NCHIPS, default 1, number of daisy-chained devices; NBITS = WIDTH*NCHIPS.
REQ-003 Parameter CLKDIV, default 4, clk cycles per serclk half-period; legal range 3..255.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request one capture-and-shift transaction; sampled only in IDLE or DONE.
REQ-007 q7  input  1  serial data from the last device in the chain; asynchronous to clk.
REQ-008 shld  output  1  shift/load to devices; 0 = parallel load, 1 = shift.
REQ-009 serclk  output  1  shift clock to devices; devices shift on its rising edge.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 out_data  output  NBITS  assembled word, MSB = first bit received.
REQ-012 out_valid  output  1  out_data valid; held until accepted.
REQ-013 out_ready  input  1  consumer accepts out_data when out_valid & out_ready.

Function
REQ-014 q7 SHALL pass through a 2-flop synchronizer before use; all sampling uses the synchronized value.
REQ-015 A divider counter SHALL time every non-IDLE, non-DONE state for exactly CLKDIV clk cycles.
REQ-016 States: IDLE, LOAD, SETTLE, LOW, HIGH, DONE.
REQ-017 IDLE: shld=1, serclk=0; start=1 -> LOAD next cycle.
REQ-018 LOAD: shld=0, serclk=0 for CLKDIV cycles -> SETTLE.
REQ-019 SETTLE: shld=1, serclk=0 for CLKDIV cycles -> LOW.
REQ-020 LOW: serclk=0; on its last cycle, shift synchronized q7 into the LSB of the assembly register (shifting left) and increment bit count; if count reaches NBITS -> DONE, else -> HIGH.
REQ-021 HIGH: serclk=1 for CLKDIV cycles -> LOW; exactly NBITS-1 serclk rising edges per transaction.
REQ-022 DONE: out_valid=1, out_data = assembled word, shld=1, serclk=0; out_ready=1 -> IDLE, or -> LOAD if start=1 in the same cycle.
REQ-023 out_data SHALL change only on entry to DONE; it holds its value through IDLE and the next transaction.
REQ-024 start while in LOAD/SETTLE/LOW/HIGH SHALL be ignored (no queuing).
REQ-025 Latency: out_valid SHALL rise exactly CLKDIV*(2*NBITS+1) clk cycles after the edge that sampled start (68 for NBITS=8, CLKDIV=4).
REQ-026 serclk and shld SHALL be driven directly from registers (glitch-free), never from combinational decode.
REQ-027 Bit counter width SHALL be clog2(NBITS+1); no wrap-around within a transaction.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, shld=1, serclk=0, busy=0, out_valid=0, out_data=0, counters=0, synchronizer=0, irrespective of clk.
REQ-029 Reset mid-transaction SHALL abort it with no out_valid pulse; first start after release begins a full new transaction.

Structure
REQ-030 Package sr165_pkg SHALL hold the state enum and constant MIN_CLKDIV=3.
REQ-031 The q7 synchronizer SHALL be sub-module sr165_sync2 (1-bit, 2 flops, async active-low reset to 0).
REQ-032 The remainder (FSM, divider, bit counter, assembly register) SHALL be in sr165_reader.

Verification (bench drives q7 from a behavioural 74x165 chain model clocked by clk)
REQ-033 NCHIPS=1, CLKDIV=4, device inputs 8'hA5, start pulse -> out_data=8'hA5, out_valid at cycle 68, shld low exactly 4 cycles, 7 serclk rising edges.
REQ-034 NCHIPS=2, device nearest q7 = 8'h3C, upstream = 8'hC3 -> out_data=16'h3CC3 after 4*33=132 cycles.
REQ-035 out_ready held low 20 cycles after out_valid -> out_valid and out_data stable; start pulses during HIGH ignored; out_ready=start=1 together -> shld falls the next cycle.
REQ-036 Back-to-back transactions with inputs 8'hFF then 8'h00 -> out_data 8'hFF then 8'h00, no stale bits.
REQ-037 rst_n asserted during HIGH of bit 4 -> serclk=0, shld=1, busy=0, out_valid=0, out_data=0 immediately; next start yields correct word.
REQ-038 CLKDIV=3 (minimum) with 8'h81 -> out_data=8'h81, verifying synchronizer latency fits the LOW phase.
